// File: rtl/uart_rx_bit_ctrl.sv
// UART receive bit-timing controller and deserializer.
// Drives an external flex_counter (clear / count_enable / rollover_val) and
// uses its rollover_flag as the mid-bit sample strobe. Frames are LSB-first;
// each frame ends in either a one-cycle rx_valid or a one-cycle framing_error.
module uart_rx_bit_ctrl #(
    parameter int CNT_BITS  = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 serial_in,
    input  logic [CNT_BITS-1:0]  bit_period,
    input  logic                 cnt_rollover_flag,
    output logic                 cnt_clear,
    output logic                 cnt_enable,
    output logic [CNT_BITS-1:0]  cnt_rollover_val,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 framing_error,
    output logic                 busy
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_BITS-1:0] MIN_PERIOD = CNT_BITS'(4);
    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                state_q,  state_d;
    logic                  line_q;
    logic [CNT_BITS-1:0]   period_q, period_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic [DATA_BITS-1:0]  shift_q,  shift_d;
    logic [DATA_BITS-1:0]  data_q,   data_d;
    logic                  valid_q,  valid_d;
    logic                  ferr_q,   ferr_d;

    logic                  strobe;
    logic                  start_det;
    logic [DATA_BITS-1:0]  shift_in;

    // New bit enters at the MSB so that after DATA_BITS shifts the first
    // (least significant) bit on the wire ends up in bit 0.
    generate
        if (DATA_BITS == 1) begin : gen_shift_single
            assign shift_in = serial_in;
        end else begin : gen_shift_multi
            assign shift_in = {serial_in, shift_q[DATA_BITS-1:1]};
        end
    endgenerate

    assign strobe    = (state_q != IDLE) && cnt_rollover_flag;
    assign start_det = line_q && !serial_in;

    // Counter drive: the half-period reload in START lands the first strobe
    // in the middle of the start bit; every later strobe is a full period on.
    assign cnt_enable       = (state_q != IDLE);
    assign cnt_clear        = (state_q == IDLE) || cnt_rollover_flag;
    assign cnt_rollover_val = (state_q == START) ? ((period_q >> 1) - CNT_BITS'(1))
                                                 : (period_q - CNT_BITS'(1));

    assign busy          = (state_q != IDLE);
    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign framing_error = ferr_q;

    // Next-state and datapath decode; pulses default low so they last one cycle.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_det) begin
                    period_d = (bit_period < MIN_PERIOD) ? MIN_PERIOD : bit_period;
                    state_d  = START;
                end
            end
            START: begin
                if (strobe) begin
                    if (serial_in) begin
                        state_d = IDLE;          // line back high: false start
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
            end
            DATA: begin
                if (strobe) begin
                    shift_d = shift_in;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (strobe) begin
                    state_d = IDLE;
                    if (serial_in) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched period, shift/data registers and output pulses.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            line_q   <= 1'b1;
            period_q <= MIN_PERIOD;
            idx_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            line_q   <= serial_in;
            period_q <= period_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_bit_ctrl.sv
// Bench for uart_rx_bit_ctrl: a behavioural flex_counter closes the loop,
// frames are driven cycle by cycle, and expected pulses (kind, word, cycle)
// are queued at frame start and popped when the DUT pulses.
module tb_uart_rx_bit_ctrl;

    localparam int DB = 8;

    logic        clk = 1'b0;
    logic        nrst;
    logic        serial_in;
    logic [7:0]  bit_period;
    logic        cnt_rollover_flag;
    logic        cnt_clear;
    logic        cnt_enable;
    logic [7:0]  cnt_rollover_val;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        framing_error;
    logic        busy;

    uart_rx_bit_ctrl #(.CNT_BITS(8), .DATA_BITS(DB)) dut (
        .clk               (clk),
        .nrst              (nrst),
        .serial_in         (serial_in),
        .bit_period        (bit_period),
        .cnt_rollover_flag (cnt_rollover_flag),
        .cnt_clear         (cnt_clear),
        .cnt_enable        (cnt_enable),
        .cnt_rollover_val  (cnt_rollover_val),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .framing_error     (framing_error),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Behavioural flex_counter: counts 1..R, registered flag while count==R.
    logic [7:0] cnt_q;
    logic [7:0] cnt_nxt;
    always_comb cnt_nxt = (cnt_q == cnt_rollover_val) ? 8'd1 : cnt_q + 8'd1;
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= 8'd0;
            cnt_rollover_flag <= 1'b0;
        end else if (cnt_clear) begin
            cnt_q <= 8'd0;
            cnt_rollover_flag <= 1'b0;
        end else if (cnt_enable) begin
            cnt_q <= cnt_nxt;
            cnt_rollover_flag <= (cnt_nxt == cnt_rollover_val);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   strobe_log[$];
    logic [7:0] last_good = 8'h00;

    // Output monitor: one line per received word / error.
    always @(negedge clk) begin
        if (nrst && busy && cnt_rollover_flag) strobe_log.push_back(cyc);
        if (nrst && (rx_valid || framing_error)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {rx_valid, framing_error}, 2'b00);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("cycle %0d: %s rx_data=%02h", cyc,
                         rx_valid ? "rx_valid" : "framing_error", rx_data);
                chk("rx_valid", rx_valid, !e.err);
                chk("framing_error", framing_error, e.err);
                chk("rx_data", rx_data, e.data);
                chk("pulse_cycle", cyc, e.cyc);
                chk("busy_in_pulse", busy, 1'b0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            serial_in = 1'b1;
        end
    endtask

    // Drive one frame cycle by cycle. abort_after>0 stops after that many
    // cycles and queues no expectation. glitch inverts the first cycle of
    // every non-start bit, which is never a sample point.
    task automatic send_frame(input logic [7:0] data, input logic stop, input int bp,
                              input int stop_len, input bit glitch, input int abort_after,
                              output int c0);
        int   p;
        int   n;
        int   len;
        logic v;
        exp_t e;
        p  = (bp < 4) ? 4 : bp;
        n  = 0;
        c0 = 0;
        for (int b = 0; b < DB + 2; b++) begin
            len = (b == DB + 1) ? stop_len : p;
            for (int o = 0; o < len; o++) begin
                @(posedge clk); #1;
                if (b == 0 && o == 0) begin
                    bit_period = bp[7:0];
                    c0 = cyc;
                    if (abort_after == 0) begin
                        e.err  = !stop;
                        e.data = stop ? data : last_good;
                        e.cyc  = c0 + (p >> 1) + (DB + 1) * p + 1;
                        if (stop) last_good = data;
                        exp_q.push_back(e);
                    end
                end
                if (b == 0)           v = 1'b0;
                else if (b <= DB)     v = data[b-1];
                else                  v = stop;
                if (glitch && b > 0 && o == 0) v = ~v;
                serial_in = v;
                n++;
                if (abort_after > 0 && n >= abort_after) return;
            end
        end
    endtask

    task automatic check_strobes(input string tag, input int c0, input int p);
        chk({tag, "_count"}, strobe_log.size(), DB + 2);
        for (int k = 0; k < DB + 2 && k < strobe_log.size(); k++)
            chk({tag, "_at"}, strobe_log[k], c0 + (p >> 1) + k * p);
        strobe_log.delete();
    endtask

    initial begin
        int c0;
        int c1;
        nrst       = 1'b0;
        serial_in  = 1'b1;
        bit_period = 8'd10;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_ferr", framing_error, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_cnt_clear", cnt_clear, 1'b1);
        chk("rst_cnt_enable", cnt_enable, 1'b0);
        chk("rst_rollover_val", cnt_rollover_val, 8'd3);
        @(posedge clk); #1;
        nrst = 1'b1;
        idle(5);
        strobe_log.delete();

        // 1: good frame 0xA5, P=10
        send_frame(8'hA5, 1'b1, 10, 10, 1'b0, 0, c0);
        idle(3);
        check_strobes("t1_strobe", c0, 10);

        // 2: false start, line low for 3 cycles
        @(posedge clk); #1;
        serial_in = 1'b0;
        c0 = cyc;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        serial_in = 1'b1;
        repeat (3) @(negedge clk);          // cycle c0+5
        chk("t2_busy_at_strobe", busy, 1'b1);
        chk("t2_flag_at_strobe", cnt_rollover_flag, 1'b1);
        @(negedge clk);                     // cycle c0+6
        chk("t2_busy_after", busy, 1'b0);
        chk("t2_cnt_clear", cnt_clear, 1'b1);
        idle(8);
        strobe_log.delete();

        // 3: framing error, rx_data held at 0xA5
        send_frame(8'h5A, 1'b0, 10, 10, 1'b0, 0, c0);
        idle(5);
        chk("t3_rx_data_held", rx_data, 8'hA5);

        // 4: asynchronous reset during data bit 3, then a good frame
        send_frame(8'h3C, 1'b1, 10, 10, 1'b0, 44, c0);
        @(posedge clk); #3;
        nrst = 1'b0;
        serial_in = 1'b1;
        last_good = 8'h00;
        #1;
        chk("t4_busy", busy, 1'b0);
        chk("t4_cnt_clear", cnt_clear, 1'b1);
        chk("t4_cnt_enable", cnt_enable, 1'b0);
        chk("t4_rx_data", rx_data, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        idle(5);
        chk("t4_idle_after_rst", busy, 1'b0);
        send_frame(8'h3C, 1'b1, 10, 10, 1'b0, 0, c0);
        idle(5);
        strobe_log.delete();

        // 5: bit_period changed mid-frame, then P=16 frame, then clamped P=2
        fork
            send_frame(8'hC3, 1'b1, 10, 10, 1'b0, 0, c0);
            begin
                repeat (40) @(posedge clk);
                #2;
                bit_period = 8'd16;
            end
        join
        idle(3);
        check_strobes("t5a_strobe", c0, 10);
        send_frame(8'h81, 1'b1, 16, 16, 1'b0, 0, c0);
        idle(3);
        check_strobes("t5b_strobe", c0, 16);
        send_frame(8'h7E, 1'b1, 2, 4, 1'b0, 0, c0);
        idle(3);
        check_strobes("t5c_strobe", c0, 4);

        // 6: back-to-back, second start bit in the rx_valid cycle
        send_frame(8'h12, 1'b1, 10, 6, 1'b0, 0, c0);
        send_frame(8'hE7, 1'b1, 10, 10, 1'b0, 0, c1);
        chk("t6_second_start", c1, c0 + 96);
        idle(5);

        // glitches between strobes are ignored
        send_frame(8'h96, 1'b1, 10, 10, 1'b1, 0, c0);
        idle(20);

        chk("pending_expectations", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_bit_ctrl.md
Name: uart_rx_bit_ctrl

Overview:
- Receive-side bit-timing controller and deserializer for the UART path.
- Sits directly upstream of a flex_counter instance: drives its clear, count_enable and rollover_val, and consumes its rollover_flag to find mid-bit sample points.
- Samples a pre-synchronized serial line LSB-first and outputs one data word per frame, with a valid pulse or a framing-error pulse.

Parameters:
CNT_BITS, 8, width of the external counter's count and rollover_val; also the width of bit_period.
DATA_BITS, 8, data bits per frame (1 to 16).

Ports:
clk  input  1  system clock
nrst  input  1  reset, asynchronous, active-low
serial_in  input  1  serial line, already synchronized; idles high
bit_period  input  CNT_BITS  clocks per bit; latched at start detection
cnt_rollover_flag  input  1  rollover_flag from the downstream counter
cnt_clear  output  1  counter clear
cnt_enable  output  1  counter count_enable
cnt_rollover_val  output  CNT_BITS  counter rollover_val
rx_data  output  DATA_BITS  last good received word
rx_valid  output  1  one-cycle pulse: rx_data updated
framing_error  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  frame in progress

Behaviour:
- Clock and reset: one clock, clk. Reset nrst is asynchronous, active-low.
- Reset values:
  - state IDLE; busy 0; rx_valid 0; framing_error 0; rx_data 0.
  - Line-history register 1. Latched period P = 4. Bit index 0.
  - Reset mid-frame aborts the frame immediately: no output pulse, rx_data unchanged from reset value.
- Counter contract: the counter counts 1..R on enable, raises its registered flag while count==R, and goes 0 on synchronous clear. Clear has priority over enable.
- FSM states: IDLE, START, DATA, STOP.
- Combinational counter drive:
  - cnt_enable = (state != IDLE).
  - cnt_clear = (state == IDLE) | cnt_rollover_flag.
  - cnt_rollover_val = (P>>1)-1 in START, otherwise P-1.
  - Consequence: from START entry, the first flag occurs P>>1 cycles after the start cycle; subsequent flags occur every P cycles.
- Strobe: a cycle where state != IDLE and cnt_rollover_flag = 1. All sampling happens on strobes only.
- IDLE:
  - A start is detected when the line-history register is 1 and serial_in is 0 (falling edge).
  - At that edge: latch P = max(bit_period, 4), go to START, busy becomes 1.
  - The line-history register tracks serial_in every cycle, in every state.
- START:
  - Strobe with serial_in = 1: false start, go to IDLE, no pulses.
  - Strobe with serial_in = 0: go to DATA, bit index = 0.
- DATA:
  - Each strobe shifts serial_in into the MSB of the shift register (LSB-first frame) and increments the bit index.
  - After the DATA_BITS-th strobe, go to STOP.
- STOP (strobe):
  - serial_in = 1: rx_data <= shift register; rx_valid = 1 next cycle.
  - serial_in = 0: framing_error = 1 next cycle; rx_data held.
  - Either way, go to IDLE at the same edge. busy is 0 in the pulse cycle.
- Pulses: rx_valid and framing_error are registered, high exactly one cycle, never both.
- Timing: with start cycle C0, strobes fall at C0+(P>>1)+k*P for k = 0..DATA_BITS+1. The output pulse is one cycle after the last strobe.
- Boundary cases:
  - bit_period < 4 is clamped to 4.
  - Changing bit_period mid-frame has no effect until the next start.
  - A falling edge in the rx_valid/framing_error cycle is a legal back-to-back start.
  - serial_in changes between strobes are ignored.
  - Line glitches while busy are ignored.

Test Plan:
1. bit_period=10, frame 0xA5 with stop bit 1, start at C0 -> strobes at C5, C15..C85, C95; rx_valid=1 only in C96; rx_data=0xA5; busy 0 from C96.
2. serial_in low 3 cycles then high, bit_period=10 -> START strobe at C5 reads 1; busy 0 from C6; no rx_valid or framing_error; cnt_clear=1 from C6.
3. Frame 0x5A with stop bit 0 after a good 0xA5 -> framing_error=1 only in C96; rx_valid stays 0; rx_data stays 0xA5.
4. nrst low for 2 cycles during data bit 3, then frame 0x3C -> outputs show reset values asynchronously: busy 0, cnt_clear 1, cnt_enable 0. Next frame gives rx_data=0x3C with rx_valid.
5. bit_period changed 10->16 mid-frame -> current frame strobes stay 10 apart; next frame strobes at C8, then every 16; rx_valid at C153. bit_period=2 -> treated as 4: strobes at C2, then every 4.
6. Back-to-back: second start bit falls in C96 of frame 1 -> accepted; second frame's first strobe at C101; both words received.
